ram_port_arb: RTL and testbench

Round-robin arbiter that shares one 1R1W register RAM (one read port, one write port, 1-cycle registered read) among NUM_PORT requesters. It drives the RAM read and write ports from independent per-port arbiters, tags each granted read, and routes read data back to the owning requester one cycle later. It sits between the PE/buffer clients of the point-cloud accelerator and each shared on-chip buffer bank.

---
 rtl/ram_port_arb.sv | 129 ++++++++++++
 tb/tb_ram_port_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arb.sv
// Round-robin sharing of one 1R1W registered-read RAM among NUM_PORT requesters.
// Define RAM_PORT_ARB_BYPASS_EN to forward same-cycle same-address write data to the read.
module ram_port_arb #(
  parameter int NUM_PORT   = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORT-1:0]              rd_req,
  input  logic [NUM_PORT*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_PORT-1:0]              rd_gnt,
  output logic [NUM_PORT-1:0]              rd_data_vld,
  output logic [DATA_WIDTH-1:0]            rd_data,
  input  logic [NUM_PORT-1:0]              wr_req,
  input  logic [NUM_PORT*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_PORT*DATA_WIDTH-1:0]   wr_data,
  output logic [NUM_PORT-1:0]              wr_gnt,
  output logic                             ram_read_en,
  output logic [ADDR_WIDTH-1:0]            ram_addr_r,
  output logic                             ram_write_en,
  output logic [ADDR_WIDTH-1:0]            ram_addr_w,
  output logic [DATA_WIDTH-1:0]            ram_data_in,
  input  logic [DATA_WIDTH-1:0]            ram_data_out
);

  localparam int PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [NUM_PORT-1:0]   tag_q;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [ADDR_WIDTH-1:0] rd_addr_m [NUM_PORT];
  logic [ADDR_WIDTH-1:0] wr_addr_m [NUM_PORT];
  logic [DATA_WIDTH-1:0] wr_data_m [NUM_PORT];

  // Search starts one past the last winner, so the last winner has lowest priority.
  function automatic logic [NUM_PORT-1:0] rr_grant(input logic [NUM_PORT-1:0] req,
                                                   input logic [PTR_W-1:0]    ptr);
    logic [NUM_PORT-1:0] g;
    logic                found;
    int                  idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORT; k++) begin
      idx = (int'(ptr) + k) % NUM_PORT;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PTR_W-1:0] oh_idx(input logic [NUM_PORT-1:0] oh);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      if (oh[k]) r = PTR_W'(k);
    end
    return r;
  endfunction

  assign rd_gnt       = rst_n ? rr_grant(rd_req, rd_ptr_q) : '0;
  assign wr_gnt       = rst_n ? rr_grant(wr_req, wr_ptr_q) : '0;
  assign ram_read_en  = |rd_gnt;
  assign ram_write_en = |wr_gnt;

  assign rd_ptr_d = ram_read_en  ? oh_idx(rd_gnt) : rd_ptr_q;
  assign wr_ptr_d = ram_write_en ? oh_idx(wr_gnt) : wr_ptr_q;

  // Grants are one-hot (or zero), so masking each port and OR-ing forms the mux.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_port_mask
      assign rd_addr_m[gi] = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{rd_gnt[gi]}};
      assign wr_addr_m[gi] = wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{wr_gnt[gi]}};
      assign wr_data_m[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{wr_gnt[gi]}};
    end
  endgenerate

  always_comb begin
    ram_addr_r  = '0;
    ram_addr_w  = '0;
    ram_data_in = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      ram_addr_r  = ram_addr_r  | rd_addr_m[k];
      ram_addr_w  = ram_addr_w  | wr_addr_m[k];
      ram_data_in = ram_data_in | wr_data_m[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= PTR_W'(NUM_PORT - 1);
      wr_ptr_q <= PTR_W'(NUM_PORT - 1);
      tag_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_q    <= rd_gnt;
    end
  end

`ifdef RAM_PORT_ARB_BYPASS_EN
  logic                  byp_vld_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_vld_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_vld_q  <= ram_read_en & ram_write_en & (ram_addr_r == ram_addr_w);
      byp_data_q <= ram_data_in;
    end
  end

  assign rd_word = byp_vld_q ? byp_data_q : ram_data_out;
`else
  assign rd_word = ram_data_out;
`endif

  // A response in flight when reset arrives is dropped in that same cycle.
  assign rd_data_vld = tag_q & {NUM_PORT{rst_n}};
  assign rd_data     = (|rd_data_vld) ? rd_word : '0;

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb with a behavioural registered-read RAM.
// Expected collision data follows RAM_PORT_ARB_BYPASS_EN when defined.
module tb_ram_port_arb;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;

`ifdef RAM_PORT_ARB_BYPASS_EN
  localparam logic [63:0] COL_EXP = 64'h2222;
`else
  localparam logic [63:0] COL_EXP = 64'h1111;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    rd_req, wr_req;
  logic [N*AW-1:0] rd_addr, wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    rd_gnt, rd_data_vld, wr_gnt;
  logic [DW-1:0]   rd_data;
  logic            ram_read_en, ram_write_en;
  logic [AW-1:0]   ram_addr_r, ram_addr_w;
  logic [DW-1:0]   ram_data_in, ram_data_out;

  logic [DW-1:0]   mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_port_arb #(.NUM_PORT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .ram_read_en(ram_read_en), .ram_addr_r(ram_addr_r),
    .ram_write_en(ram_write_en), .ram_addr_w(ram_addr_w),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Registered-read RAM; read-before-write on a same-address collision.
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
    if (ram_read_en)  ram_data_out    <= mem[ram_addr_r];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rd_req = '0;
    wr_req = '0;
  endtask

  initial begin
    logic [N-1:0] e;
    rst_n   = 1'b0;
    rd_req  = '1;
    wr_req  = '1;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '1;

    // Reset with every port requesting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_rd_gnt", 64'(rd_gnt), 64'h0);
      check("rst_wr_gnt", 64'(wr_gnt), 64'h0);
      check("rst_ren", 64'(ram_read_en), 64'h0);
      check("rst_wen", 64'(ram_write_en), 64'h0);
      check("rst_vld", 64'(rd_data_vld), 64'h0);
      check("rst_rdata", rd_data, 64'h0);
      check("rst_addr_w", 64'(ram_addr_w), 64'h0);
      check("rst_data_in", ram_data_in, 64'h0);
    end
    tick();
    rst_n = 1'b1;
    clr();

    // Single port write then read
    wr_req = 4'b0100;
    wr_addr[2*AW +: AW] = 10'h010;
    wr_data[2*DW +: DW] = 64'hA5A5;
    @(negedge clk);
    check("sp_wr_gnt", 64'(wr_gnt), 64'h4);
    check("sp_addr_w", 64'(ram_addr_w), 64'h010);
    check("sp_data_in", ram_data_in, 64'hA5A5);
    check("sp_ren_idle", 64'(ram_read_en), 64'h0);
    tick();
    clr();
    rd_req = 4'b0100;
    rd_addr[2*AW +: AW] = 10'h010;
    @(negedge clk);
    check("sp_rd_gnt", 64'(rd_gnt), 64'h4);
    check("sp_addr_r", 64'(ram_addr_r), 64'h010);
    check("sp_vld_early", 64'(rd_data_vld), 64'h0);
    tick();
    clr();
    @(negedge clk);
    check("sp_vld", 64'(rd_data_vld), 64'h4);
    check("sp_rdata", rd_data, 64'hA5A5);

    // Fairness after a fresh reset
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    rd_req = 4'hF;
    for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = 10'h010;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = 4'b0001 << (k % 4);
      check($sformatf("fair_gnt%0d", k), 64'(rd_gnt), 64'(e));
      if (k > 0) begin
        e = 4'b0001 << ((k - 1) % 4);
        check($sformatf("fair_vld%0d", k), 64'(rd_data_vld), 64'(e));
        check($sformatf("fair_data%0d", k), rd_data, 64'hA5A5);
      end
      tick();
    end
    clr();
    @(negedge clk);
    check("fair_vld_last", 64'(rd_data_vld), 64'h8);
    check("fair_gnt_idle", 64'(rd_gnt), 64'h0);

    // Idle cycles keep the pointer at port 1
    tick();
    rd_req = 4'b1010;
    @(negedge clk);
    check("idle_gnt_first", 64'(rd_gnt), 64'h2);
    tick();
    clr();
    @(negedge clk);
    check("idle_gnt_gap0", 64'(rd_gnt), 64'h0);
    tick();
    @(negedge clk);
    check("idle_gnt_gap1", 64'(rd_gnt), 64'h0);
    tick();
    rd_req = 4'b1010;
    @(negedge clk);
    check("idle_gnt_next", 64'(rd_gnt), 64'h8);
    tick();
    clr();

    // Same-cycle read and write to one address
    wr_req = 4'b0001;
    wr_addr[0 +: AW] = 10'h020;
    wr_data[0 +: DW] = 64'h1111;
    @(negedge clk);
    check("col_pre_wgnt", 64'(wr_gnt), 64'h1);
    tick();
    wr_data[0 +: DW] = 64'h2222;
    rd_req = 4'b0010;
    rd_addr[1*AW +: AW] = 10'h020;
    @(negedge clk);
    check("col_wgnt", 64'(wr_gnt), 64'h1);
    check("col_rgnt", 64'(rd_gnt), 64'h2);
    tick();
    clr();
    @(negedge clk);
    check("col_vld", 64'(rd_data_vld), 64'h2);
    check("col_rdata", rd_data, COL_EXP);
    tick();
    rd_req = 4'b0010;
    @(negedge clk);
    tick();
    clr();
    @(negedge clk);
    check("col_after", rd_data, 64'h2222);

    // Reset arrives while a read is in flight
    tick();
    rd_req = 4'b0001;
    rd_addr[0 +: AW] = 10'h010;
    @(negedge clk);
    check("mr_gnt", 64'(rd_gnt), 64'h1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_vld_rst", 64'(rd_data_vld), 64'h0);
    check("mr_rdata_rst", rd_data, 64'h0);
    check("mr_gnt_rst", 64'(rd_gnt), 64'h0);
    tick();
    rst_n = 1'b1;
    clr();
    @(negedge clk);
    check("mr_vld_post0", 64'(rd_data_vld), 64'h0);
    tick();
    @(negedge clk);
    check("mr_vld_post1", 64'(rd_data_vld), 64'h0);
    check("mr_rdata_post1", rd_data, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
